// File: rtl/fetch_bp.sv
// RV32I instruction-fetch stage: owns the fetch PC and picks the next PC using a
// direct-mapped 2-bit counter table plus BTB, trained from EX and redirected on mispredict.
module fetch_bp #(
    parameter logic [31:0] START_PC = 32'h0000_8000,
    parameter int          IDX_BITS = 6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        fail_predictD,
    input  logic        fail_predictE,
    input  logic [31:0] nextpc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instF,
    output logic        pred_takenF,
    output logic [31:0] pred_pcF
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]    tag_t;

    typedef struct packed {
        tag_t        tag;
        logic [31:0] target;
    } btb_entry_t;

    logic [31:0]             pc_q;
    logic [ENTRIES-1:0][1:0] cnt;
    logic [ENTRIES-1:0]      valid;
    btb_entry_t              btb [ENTRIES];

    idx_t       look_idx, upd_idx;
    tag_t       look_tag, upd_tag;
    btb_entry_t look_ent;
    logic       hit;
    logic [1:0] cnt_nxt;
    logic       unused_upd_lsb;

    assign look_idx = pc_q[IDX_BITS+1:2];
    assign look_tag = pc_q[31:IDX_BITS+2];
    assign upd_idx  = upd_pc[IDX_BITS+1:2];
    assign upd_tag  = upd_pc[31:IDX_BITS+2];
    assign unused_upd_lsb = ^upd_pc[1:0];

    // Lookup reads the registered tables, so a same-cycle update is not visible yet.
    assign look_ent    = btb[look_idx];
    assign hit         = valid[look_idx] && (look_ent.tag == look_tag);
    assign pred_takenF = hit && cnt[look_idx][1];
    assign pred_pcF    = pred_takenF ? look_ent.target : pc_q + 32'd4;

    assign pcF       = pc_q;
    assign imem_addr = pc_q;
    assign instF     = imem_rdata;

    always_comb begin
        cnt_nxt = cnt[upd_idx];
        if (upd_taken) begin
            if (cnt[upd_idx] != 2'b11) cnt_nxt = cnt[upd_idx] + 2'b01;
        end else begin
            if (cnt[upd_idx] != 2'b00) cnt_nxt = cnt[upd_idx] - 2'b01;
        end
    end

    // Redirect wins over stall: the mispredicted instruction has already left F.
    always_ff @(posedge CLK) begin
        if (RST)                                pc_q <= START_PC;
        else if (fail_predictD | fail_predictE) pc_q <= nextpc;
        else if (!stall)                        pc_q <= pred_pcF;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= {ENTRIES{2'b01}};
            valid <= '0;
        end else if (upd_valid) begin
            cnt[upd_idx] <= cnt_nxt;
            if (upd_taken) valid[upd_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset; the valid bit guards them. Not-taken never clears an entry.
    always_ff @(posedge CLK) begin
        if (!RST && upd_valid && upd_taken)
            btb[upd_idx] <= '{tag: upd_tag, target: upd_target};
    end

endmodule

// File: tb/tb_fetch_bp.sv
// Bench for fetch_bp: directed plan steps plus a random phase, all checked against
// an array-based predictor model computed from the prediction/training rules.
module tb_fetch_bp;

    localparam int          IDX = 6;
    localparam int          N   = 1 << IDX;
    localparam logic [31:0] SPC = 32'h0000_8000;

    logic        CLK = 1'b0;
    logic        RST, stall, fail_predictD, fail_predictE, upd_valid, upd_taken;
    logic [31:0] nextpc, upd_pc, upd_target, imem_rdata;
    logic [31:0] imem_addr, pcF, instF, pred_pcF;
    logic        pred_takenF;

    int checks   = 0;
    int failures = 0;

    // Reference state: plain integers and arrays
    logic [31:0] m_pc;
    int          m_cnt [N];
    bit          m_vld [N];
    logic [31:0] m_tag [N];
    logic [31:0] m_tgt [N];

    fetch_bp #(.START_PC(SPC), .IDX_BITS(IDX)) dut (
        .CLK(CLK), .RST(RST), .stall(stall),
        .fail_predictD(fail_predictD), .fail_predictE(fail_predictE),
        .nextpc(nextpc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pcF(pcF), .instF(instF), .pred_takenF(pred_takenF), .pred_pcF(pred_pcF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = SPC;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 1;
            m_vld[i] = 1'b0;
        end
    endtask

    task automatic m_predict(output logic taken, output logic [31:0] npc);
        int          i;
        logic [31:0] t;
        i     = int'((m_pc / 4) % N);
        t     = m_pc >> (IDX + 2);
        taken = m_vld[i] && (m_tag[i] == t) && (m_cnt[i] >= 2);
        npc   = taken ? m_tgt[i] : m_pc + 32'd4;
    endtask

    // Check outputs against the model, clock once, then advance the model.
    task automatic cyc();
        logic        pt;
        logic [31:0] ppc;
        int          i;
        m_predict(pt, ppc);
        chk("pcF", pcF, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("instF", instF, imem_rdata);
        chk("pred_takenF", {31'b0, pred_takenF}, {31'b0, pt});
        chk("pred_pcF", pred_pcF, ppc);
        @(posedge CLK);
        if (RST) m_reset();
        else begin
            if (upd_valid) begin
                i = int'((upd_pc / 4) % N);
                if (upd_taken) begin
                    m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                    m_vld[i] = 1'b1;
                    m_tag[i] = upd_pc >> (IDX + 2);
                    m_tgt[i] = upd_target;
                end else begin
                    m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end
            if (fail_predictD || fail_predictE) m_pc = nextpc;
            else if (!stall)                    m_pc = ppc;
        end
        #1;
    endtask

    initial begin
        RST = 1'b1; stall = 1'b0; fail_predictD = 1'b0; fail_predictE = 1'b0;
        nextpc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        imem_rdata = 32'h0000_0013;
        @(posedge CLK);
        m_reset();
        #1;
        RST = 1'b0;

        // Reset state and free-running fetch
        chk("rst_pc", pcF, 32'h8000);
        chk("rst_pt", {31'b0, pred_takenF}, 32'd0);
        chk("rst_ppc", pred_pcF, 32'h8004);
        cyc(); cyc(); cyc();
        chk("seq_pc", pcF, 32'h800C);

        // Train 8010 taken twice while holding fetch
        stall = 1'b1; upd_valid = 1'b1; upd_pc = 32'h8010; upd_taken = 1'b1; upd_target = 32'h8100;
        cyc(); cyc();
        upd_valid = 1'b0; stall = 1'b0;
        cyc();
        chk("trained_pc", pcF, 32'h8010);
        chk("trained_pt", {31'b0, pred_takenF}, 32'd1);
        chk("trained_ppc", pred_pcF, 32'h8100);
        cyc();
        chk("zero_bubble", pcF, 32'h8100);

        // One not-taken keeps the prediction; redirect back to 8010 at the same time
        upd_valid = 1'b1; upd_taken = 1'b0; fail_predictE = 1'b1; nextpc = 32'h8010;
        cyc();
        upd_valid = 1'b0; fail_predictE = 1'b0;
        chk("weak_taken", {31'b0, pred_takenF}, 32'd1);
        // Same-cycle update at the looked-up index sees old counter
        stall = 1'b1; upd_valid = 1'b1;
        chk("rbw_old", {31'b0, pred_takenF}, 32'd1);
        cyc();
        upd_valid = 1'b0;
        chk("rbw_new_pt", {31'b0, pred_takenF}, 32'd0);
        chk("rbw_new_ppc", pred_pcF, 32'h8014);
        stall = 1'b0;

        // Redirect beats stall; stall alone holds
        fail_predictD = 1'b1; nextpc = 32'h8020;
        cyc();
        fail_predictD = 1'b0; stall = 1'b1; fail_predictE = 1'b1; nextpc = 32'h9000;
        cyc();
        chk("redir_over_stall", pcF, 32'h9000);
        fail_predictE = 1'b0; fail_predictD = 1'b1; nextpc = 32'h8020; stall = 1'b0;
        cyc();
        fail_predictD = 1'b0; stall = 1'b1;
        cyc(); cyc();
        chk("stall_hold", pcF, 32'h8020);
        stall = 1'b0;

        // Aliasing entry overwrites 8010's BTB slot
        stall = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1;
        upd_pc = 32'h8010 + (32'd4 << IDX); upd_target = 32'h8200;
        cyc();
        upd_valid = 1'b0; stall = 1'b0; fail_predictE = 1'b1; nextpc = 32'h8010;
        cyc();
        fail_predictE = 1'b0;
        chk("alias_miss_pt", {31'b0, pred_takenF}, 32'd0);
        chk("alias_miss_ppc", pred_pcF, 32'h8014);
        fail_predictE = 1'b1; nextpc = 32'h8110;
        cyc();
        fail_predictE = 1'b0;
        chk("alias_hit_ppc", pred_pcF, 32'h8200);

        // PC+4 wraps
        fail_predictD = 1'b1; nextpc = 32'hFFFF_FFFC;
        cyc();
        fail_predictD = 1'b0;
        chk("wrap_ppc", pred_pcF, 32'h0);
        cyc();
        chk("wrap_pc", pcF, 32'h0);

        // Mid-run reset suppresses a concurrent update and clears the tables
        RST = 1'b1; upd_valid = 1'b1; upd_pc = 32'h8110; upd_taken = 1'b1; upd_target = 32'h8300;
        cyc();
        RST = 1'b0; upd_valid = 1'b0;
        chk("midrst_pc", pcF, 32'h8000);
        fail_predictE = 1'b1; nextpc = 32'h8110;
        cyc();
        fail_predictE = 1'b0;
        chk("midrst_cleared", {31'b0, pred_takenF}, 32'd0);

        // Random phase in a small PC window so aliasing and saturation occur often
        for (int k = 0; k < 500; k++) begin
            RST           = ($urandom_range(0, 99) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            fail_predictD = ($urandom_range(0, 7) == 0);
            fail_predictE = ($urandom_range(0, 7) == 0);
            nextpc        = SPC + 32'($urandom_range(0, 127)) * 4;
            upd_valid     = ($urandom_range(0, 1) == 1);
            upd_pc        = SPC + 32'($urandom_range(0, 127)) * 4;
            upd_taken     = ($urandom_range(0, 2) != 0);
            upd_target    = SPC + 32'($urandom_range(0, 127)) * 4;
            imem_rdata    = $urandom;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
